// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM type and constants for the instruction fetch unit
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/fetch_out_reg.sv
// fetch_out_reg: valid/ready output stage holding one fetched instruction
module fetch_out_reg (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        load_i,
  input  logic        ready_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);
  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  // flush beats load, load beats drain; otherwise the stage holds (stall)
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end
  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with stall, redirect and fault halt
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  input  logic        ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        fault_o,
  output logic [31:0] fault_pc_o,
  output logic [31:0] fetch_count_o
);
  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - INSTR_BYTES);
  fetch_state_t state_q;
  logic [31:0]  pc_q, pc_d, fault_pc_q, fetch_count_q;
  logic         fault_q, can_load, out_of_range, load;
  assign pc_d         = pc_q + 32'(INSTR_BYTES);
  assign can_load     = !valid_o || ready_i;
  assign out_of_range = pc_q > LAST_PC;
  assign load         = (state_q == RUN) && can_load && !out_of_range && !redirect_i;
  fetch_out_reg u_out (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush_i(redirect_i),
    .load_i (load),
    .ready_i(ready_i),
    .instr_i(imem_data_i),
    .pc_i   (pc_q),
    .valid_o(valid_o),
    .instr_o(instr_o),
    .pc_o   (pc_o)
  );
  // control FSM, PC, fault capture and handshake counter; redirect overrides everything
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      fault_q       <= 1'b0;
      fault_pc_q    <= '0;
      fetch_count_q <= '0;
    end else begin
      if (valid_o && ready_i) fetch_count_q <= fetch_count_q + 32'd1;
      if (redirect_i) begin
        pc_q <= redirect_pc_i;
        if (redirect_pc_i[1:0] == 2'b00) begin
          state_q <= RUN;
          fault_q <= 1'b0;
        end else begin
          state_q    <= HALT;
          fault_q    <= 1'b1;
          fault_pc_q <= redirect_pc_i;
        end
      end else begin
        case (state_q)
          IDLE: state_q <= RUN;
          RUN: begin
            if (can_load && out_of_range) begin
              state_q    <= HALT;
              fault_q    <= 1'b1;
              fault_pc_q <= pc_q;
            end else if (can_load) begin
              pc_q <= pc_d;
            end
          end
          default: state_q <= HALT;
        endcase
      end
    end
  end
  assign imem_addr_o   = pc_q;
  assign fault_o       = fault_q;
  assign fault_pc_o    = fault_pc_q;
  assign fetch_count_o = fetch_count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch_unit bench against a behavioural reference model
module tb_fetch_unit;
  localparam int MEM_BYTES = 1024;
  logic        clk = 1'b0;
  logic        rst_n, ready, redir;
  logic [31:0] redir_pc;
  logic [31:0] imem_addr, imem_data, instr, pc_out, fault_pc, fcount;
  logic        valid, fault;
  logic [31:0] mem [MEM_BYTES/4];
  int          n_cmp = 0;
  int          n_err = 0;
  // reference model: what decode should see, from the fetch rules
  logic        m_starting, m_halted, m_valid, m_fault;
  logic [31:0] m_pc, m_instr, m_pco, m_fpc, m_cnt;

  always #5 clk = ~clk;

  assign imem_data = (imem_addr < MEM_BYTES) ? mem[imem_addr[9:2]] : 32'hBAD0_BAD0;

  fetch_unit #(.RESET_PC(32'h0), .MEM_BYTES(MEM_BYTES)) dut (
    .clk_i(clk), .rst_ni(rst_n), .imem_addr_o(imem_addr), .imem_data_i(imem_data),
    .instr_o(instr), .pc_o(pc_out), .valid_o(valid), .ready_i(ready),
    .redirect_i(redir), .redirect_pc_i(redir_pc), .fault_o(fault),
    .fault_pc_o(fault_pc), .fetch_count_o(fcount)
  );

  always @(posedge clk) begin
    if (!rst_n) begin
      m_starting <= 1'b1; m_halted <= 1'b0; m_pc <= 32'h0; m_valid <= 1'b0;
      m_instr <= '0; m_pco <= '0; m_fault <= 1'b0; m_fpc <= '0; m_cnt <= '0;
    end else begin
      if (m_valid && ready) m_cnt <= m_cnt + 1;
      if (redir) begin
        m_valid <= 1'b0; m_pc <= redir_pc; m_starting <= 1'b0;
        m_halted <= (redir_pc % 4) != 0;
        m_fault <= (redir_pc % 4) != 0;
        if ((redir_pc % 4) != 0) m_fpc <= redir_pc;
      end else if (m_starting) begin
        m_starting <= 1'b0;
      end else if (!m_valid || ready) begin
        if (m_halted) begin
          m_valid <= 1'b0;
        end else if (m_pc > MEM_BYTES - 4) begin
          m_halted <= 1'b1; m_fault <= 1'b1; m_fpc <= m_pc; m_valid <= 1'b0;
        end else begin
          m_instr <= mem[m_pc / 4]; m_pco <= m_pc; m_valid <= 1'b1; m_pc <= m_pc + 4;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("valid", 32'(valid), 32'(m_valid));
    check("instr", instr, m_instr);
    check("pc_o", pc_out, m_pco);
    check("fault", 32'(fault), 32'(m_fault));
    if (m_fault) check("fault_pc", fault_pc, m_fpc);
    check("count", fcount, m_cnt);
    check("imem_addr", imem_addr, m_pc);
  endtask

  // apply one cycle of inputs, then compare everything at the following negedge
  task automatic cyc(input logic r, input logic rdy, input logic rd, input logic [31:0] rp);
    rst_n = r; ready = rdy; redir = rd; redir_pc = rp;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [31:0] c0, t;
    for (int i = 0; i < MEM_BYTES / 4; i++) mem[i] = $urandom;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_count", fcount, 0);
    cyc(1, 1, 0, 0);
    check("first_idle", 32'(valid), 0);
    cyc(1, 1, 0, 0);
    check("first_valid", 32'(valid), 1);
    check("first_instr", instr, 32'h11);
    cyc(1, 1, 0, 0);
    check("second_instr", instr, 32'h22);
    check("second_pc", pc_out, 32'h4);
    c0 = fcount;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0);
      check("stall_pc", pc_out, 32'h4);
      check("stall_instr", instr, 32'h22);
      check("stall_count", fcount, c0);
    end
    cyc(1, 1, 0, 0);
    check("after_stall_pc", pc_out, 32'h8);
    check("after_stall_instr", instr, 32'h33);
    cyc(1, 0, 1, 32'h40);
    check("redir_flush", 32'(valid), 0);
    cyc(1, 0, 0, 0);
    check("redir_pc", pc_out, 32'h40);
    check("redir_valid", 32'(valid), 1);
    cyc(1, 1, 1, 32'h42);
    check("mis_fault", 32'(fault), 1);
    check("mis_fault_pc", fault_pc, 32'h42);
    check("mis_valid", 32'(valid), 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    check("halt_valid", 32'(valid), 0);
    cyc(1, 1, 1, 32'h0);
    check("clear_fault", 32'(fault), 0);
    cyc(1, 1, 0, 0);
    check("resume_pc", pc_out, 32'h0);
    check("resume_valid", 32'(valid), 1);
    cyc(1, 1, 1, 32'h3F8);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    check("end_pc", pc_out, 32'h3FC);
    check("end_valid", 32'(valid), 1);
    cyc(1, 1, 0, 0);
    check("oor_fault", 32'(fault), 1);
    check("oor_fault_pc", fault_pc, 32'h400);
    check("oor_valid", 32'(valid), 0);
    cyc(1, 1, 0, 0);
    check("oor_no_valid", 32'(valid), 0);
    cyc(1, 1, 1, 32'h0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    check("pre_rst_valid", 32'(valid), 1);
    cyc(0, 0, 0, 0);
    check("mid_rst_valid", 32'(valid), 0);
    check("mid_rst_instr", instr, 0);
    check("mid_rst_pc", pc_out, 0);
    check("mid_rst_fault", 32'(fault), 0);
    check("mid_rst_fault_pc", fault_pc, 0);
    check("mid_rst_count", fcount, 0);
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: t = 32'($urandom_range(0, MEM_BYTES / 4 - 1)) << 2;
        1: t = (32'($urandom_range(0, MEM_BYTES / 4 - 1)) << 2) | 32'($urandom_range(1, 3));
        2: t = 32'(MEM_BYTES - 16) + (32'($urandom_range(0, 5)) << 2);
        default: t = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
      endcase
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 99) < 6, t);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first byte address fetched after reset.
REQ-002 Parameter MEM_BYTES, default 1024, size of the byte-addressed instruction memory.
REQ-003 Port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port rst_ni, input, 1, reset, synchronous, active-low.
REQ-005 Port imem_addr_o, output, 32, byte address to instr_mem addr_i; combinational from the PC register.
REQ-006 Port imem_data_i, input, 32, little-endian word from instr_mem read_data_o, valid in the same cycle.
REQ-007 Port instr_o, output, 32, registered instruction to decode.
REQ-008 Port pc_o, output, 32, registered byte address of instr_o.
REQ-009 Port valid_o, output, 1, instr_o/pc_o hold a valid instruction.
REQ-010 Port ready_i, input, 1, decode accepts instr_o this cycle.
REQ-011 Port redirect_i, input, 1, branch/jump taken; flush and restart fetch.
REQ-012 Port redirect_pc_i, input, 32, target byte address for redirect_i.
REQ-013 Port fault_o, output, 1, fetch halted on misaligned or out-of-range PC.
REQ-014 Port fault_pc_o, output, 32, offending PC; holds until next redirect or reset.
REQ-015 Port fetch_count_o, output, 32, count of handshakes (valid_o & ready_i).

Function
REQ-016 FSM states are IDLE, RUN and HALT.
REQ-017 IDLE -> RUN unconditionally after one cycle; no fetch is loaded in IDLE.
REQ-018 In RUN, the output stage loads when (!valid_o | ready_i): instr_o<=imem_data_i, pc_o<=pc, valid_o<=1, pc<=pc+4.
REQ-019 In RUN with valid_o=1 and ready_i=0, instr_o/pc_o/valid_o/pc are held unchanged (stall).
REQ-020 Fetch-to-output latency is 1 cycle; sustained throughput is 1 instruction/cycle while ready_i=1.
REQ-021 Out-of-range fetch (pc > MEM_BYTES-4): no load; RUN -> HALT, fault_o<=1, fault_pc_o<=pc; an already-valid output still drains on ready_i.
REQ-022 redirect_i in any state has priority over load and stall: valid_o<=0 next cycle and pc<=redirect_pc_i; ready_i is ignored.
REQ-023 Aligned redirect (redirect_pc_i[1:0]==0) -> RUN, fault_o<=0; first redirected instruction valid 2 cycles after redirect_i.
REQ-024 Misaligned redirect -> HALT, fault_o<=1, fault_pc_o<=redirect_pc_i, valid_o<=0.
REQ-025 HALT exits only via an aligned redirect or reset.
REQ-026 PC arithmetic is 32-bit unsigned; pc+4 wraps modulo 2^32, and a wrap is caught by REQ-021.
REQ-027 fetch_count_o increments by 1 on each cycle with valid_o & ready_i, including the cycle redirect_i is high; wraps modulo 2^32.

Reset
REQ-028 While rst_ni=0 at a clock edge: state<=IDLE, pc<=RESET_PC, valid_o<=0, instr_o<=0, pc_o<=0, fault_o<=0, fault_pc_o<=0, fetch_count_o<=0.
REQ-029 Reset during a stall or redirect discards the pending instruction; no handshake is counted in that cycle.

Structure
REQ-030 A shared package fetch_pkg holds the FSM enum fetch_state_t, the constant INSTR_BYTES=4 and the NOP encoding 32'h0000_0013.
REQ-031 The output register stage is one sub-module, fetch_out_reg, implementing the valid/ready hold and flush; the FSM and PC stay in fetch_unit.

Verification
REQ-032 Reset with RESET_PC=0 and ready_i=1, memory words 0x11,0x22,0x33 at 0,4,8: instr_o sequence 0x11,0x22,0x33 with pc_o 0,4,8; first valid_o on the 2nd cycle after reset release.
REQ-033 Hold ready_i=0 for 3 cycles with pc_o=4: instr_o and pc_o stay constant and fetch_count_o does not change; after release pc_o=8 follows in the next cycle.
REQ-034 redirect_i=1 with redirect_pc_i=0x40 while valid_o=1 and ready_i=0: valid_o=0 next cycle, then pc_o=0x40 one cycle later.
REQ-035 redirect_pc_i=0x42: fault_o=1, fault_pc_o=0x42, valid_o stays 0; a later redirect to 0x0 clears fault_o and fetch resumes.
REQ-036 Sequential fetch to pc=0x3FC then 0x400 with MEM_BYTES=1024: 0x3FC is delivered; at 0x400, fault_o=1, fault_pc_o=0x400 and no further valid_o.
REQ-037 Assert rst_ni=0 mid-stall: all outputs take their reset values on the next edge.
